// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_WAIT,
        ST_KSA_GO,
        ST_KSA_WAIT,
        ST_DEC_GO,
        ST_DEC_WAIT,
        ST_DEC_ABORT,
        ST_CHECK,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_FAIL,
        ST_ERR
    } search_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INIT = 2'd1,
        OWN_KSA  = 2'd2,
        OWN_DEC  = 2'd3
    } mem_owner_e;

    localparam logic [7:0] CHAR_LO     = 8'h61;
    localparam logic [7:0] CHAR_HI     = 8'h7A;
    localparam logic [7:0] CHAR_SP     = 8'h20;
    localparam logic [1:0] SEL_DEC_OUT = 2'd3;

    // A plaintext byte is acceptable if it is a lowercase letter or a space.
    function automatic logic is_clean_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
    endfunction

endpackage

// File: rtl/rc4_phase_watchdog.sv
// Cycle counter that bounds how long the sequencer waits on one phase FSM.
module rc4_phase_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the cycle whose edge would carry the count to TIMEOUT_CYC-1.
    assign expired = enable && !clear && (cnt_q == CNT_W'(TIMEOUT_CYC - 2));

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Top-level sequencer for RC4 brute-force key search (INIT -> KSA -> DECRYPT per key).
// Optional early abort on the first bad plaintext byte: define KEY_SEARCH_EARLY_ABORT_EN.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int               KEY_W       = 24,
    parameter logic [KEY_W-1:0] KEY_START   = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_LAST    = 24'h3FFFFF,
    parameter int               MSG_LEN     = 32,
    parameter int               TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [KEY_W-1:0] key_out,
    output logic             init_start,
    input  logic             init_finish,
    output logic             ksa_start,
    input  logic             ksa_finish,
    output logic             dec_start,
    input  logic             dec_finish,
    output logic [4:0]       dec_iterations,
    output logic             dec_abort,
    output logic [1:0]       mem_owner,
    input  logic             mon_wen,
    input  logic [1:0]       mon_sel,
    input  logic [7:0]       mon_data,
    output logic             busy,
    output logic             found,
    output logic             failed,
    output logic             timeout_err
);

    search_state_e    state_q;
    search_state_e    state_d;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;
    logic             bad_q;
    logic             bad_d;

    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired;
    logic       bad_write;
    logic       abort_hit;
    mem_owner_e owner;

    assign bad_write = mon_wen && (mon_sel == SEL_DEC_OUT) && !is_clean_char(mon_data);

`ifdef KEY_SEARCH_EARLY_ABORT_EN
    assign abort_hit = bad_write;
    assign dec_abort = (state_q == ST_DEC_ABORT);
`else
    assign abort_hit = 1'b0;
    assign dec_abort = 1'b0;
`endif

    assign wd_clear  = (state_q == ST_INIT_GO) || (state_q == ST_KSA_GO) || (state_q == ST_DEC_GO);
    assign wd_enable = (state_q == ST_INIT_WAIT) || (state_q == ST_KSA_WAIT) || (state_q == ST_DEC_WAIT);

    rc4_phase_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        bad_d   = bad_q;
        unique case (state_q)
            ST_IDLE, ST_FOUND, ST_FAIL, ST_ERR: begin
                if (start) begin
                    state_d = ST_INIT_GO;
                    key_d   = KEY_START;
                end
            end
            ST_INIT_GO: state_d = ST_INIT_WAIT;
            // A finish pulse in the expiry cycle still counts as success.
            ST_INIT_WAIT: begin
                if (init_finish) begin
                    state_d = ST_KSA_GO;
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_KSA_GO: state_d = ST_KSA_WAIT;
            ST_KSA_WAIT: begin
                if (ksa_finish) begin
                    state_d = ST_DEC_GO;
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DEC_GO: begin
                bad_d   = 1'b0;
                state_d = ST_DEC_WAIT;
            end
            ST_DEC_WAIT: begin
                if (bad_write) begin
                    bad_d = 1'b1;
                end
                if (abort_hit) begin
                    state_d = ST_DEC_ABORT;
                end else if (dec_finish) begin
                    state_d = ST_CHECK;
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_DEC_ABORT: state_d = ST_NEXT_KEY;
            ST_CHECK: state_d = bad_q ? ST_NEXT_KEY : ST_FOUND;
            ST_NEXT_KEY: begin
                if (key_q == KEY_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    key_d   = key_q + KEY_W'(1);
                    state_d = ST_INIT_GO;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= KEY_START;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            bad_q   <= bad_d;
        end
    end

    always_comb begin
        owner = OWN_NONE;
        unique case (state_q)
            ST_INIT_GO, ST_INIT_WAIT:              owner = OWN_INIT;
            ST_KSA_GO, ST_KSA_WAIT:                owner = OWN_KSA;
            ST_DEC_GO, ST_DEC_WAIT, ST_DEC_ABORT:  owner = OWN_DEC;
            default:                               owner = OWN_NONE;
        endcase
    end

    assign mem_owner      = owner;
    assign key_out        = key_q;
    assign dec_iterations = 5'(MSG_LEN - 1);
    assign init_start     = (state_q == ST_INIT_GO);
    assign ksa_start      = (state_q == ST_KSA_GO);
    assign dec_start      = (state_q == ST_DEC_GO);
    assign found          = (state_q == ST_FOUND);
    assign failed         = (state_q == ST_FAIL);
    assign timeout_err    = (state_q == ST_ERR);
    assign busy           = !((state_q == ST_IDLE) || (state_q == ST_FOUND) ||
                              (state_q == ST_FAIL) || (state_q == ST_ERR));

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with behavioural init/KSA/decrypt phase models.
module tb_rc4_key_search_ctrl;

    localparam logic [23:0] TB_KEY_LAST = 24'h000003;
    localparam int          TB_TIMEOUT  = 16;
    localparam int          PHASE_CYC   = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] key_out;
    logic        init_start, init_finish;
    logic        ksa_start, ksa_finish;
    logic        dec_start, dec_finish;
    logic [4:0]  dec_iterations;
    logic        dec_abort;
    logic [1:0]  mem_owner;
    logic        mon_wen;
    logic [1:0]  mon_sel;
    logic [7:0]  mon_data;
    logic        busy, found, failed, timeout_err;

    always #5 clk = ~clk;

    rc4_key_search_ctrl #(
        .KEY_LAST    (TB_KEY_LAST),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .key_out        (key_out),
        .init_start     (init_start),
        .init_finish    (init_finish),
        .ksa_start      (ksa_start),
        .ksa_finish     (ksa_finish),
        .dec_start      (dec_start),
        .dec_finish     (dec_finish),
        .dec_iterations (dec_iterations),
        .dec_abort      (dec_abort),
        .mem_owner      (mem_owner),
        .mon_wen        (mon_wen),
        .mon_sel        (mon_sel),
        .mon_data       (mon_data),
        .busy           (busy),
        .found          (found),
        .failed         (failed),
        .timeout_err    (timeout_err)
    );

    // Phase model knobs
    logic [3:0] bad_keys;
    int         bad_pos;
    logic [7:0] bad_char;
    bit         ksa_hang;

    int init_cnt, ksa_cnt, dec_cnt;
    bit init_act, ksa_act, dec_act, dec_bad;
    int init_pulses, start_pulses, abort_pulses;
    bit bad_sent;

    int n_total = 0;
    int n_bad   = 0;

    // Phase models: react at the falling edge so the DUT samples settled inputs.
    initial begin
        init_finish = 1'b0; ksa_finish = 1'b0; dec_finish = 1'b0;
        mon_wen = 1'b0; mon_sel = 2'd0; mon_data = 8'h00;
        init_act = 1'b0; ksa_act = 1'b0; dec_act = 1'b0; dec_bad = 1'b0;
        init_cnt = 0; ksa_cnt = 0; dec_cnt = 0;
        init_pulses = 0; start_pulses = 0; abort_pulses = 0; bad_sent = 1'b0;
        forever begin
            @(negedge clk);
            init_finish = 1'b0; ksa_finish = 1'b0; dec_finish = 1'b0;
            mon_wen = 1'b0; mon_sel = 2'd0; mon_data = 8'h00; bad_sent = 1'b0;
            if (reset) begin
                init_act = 1'b0; ksa_act = 1'b0; dec_act = 1'b0;
            end else begin
                if (init_start || ksa_start || dec_start) start_pulses++;
                if (dec_abort) begin
                    abort_pulses++;
                    dec_act = 1'b0;
                end
                if (init_start) begin
                    init_act = 1'b1; init_cnt = 0; init_pulses++;
                end else if (init_act) begin
                    init_cnt++;
                    if (init_cnt == PHASE_CYC) begin init_finish = 1'b1; init_act = 1'b0; end
                end
                if (ksa_start) begin
                    ksa_act = 1'b1; ksa_cnt = 0;
                end else if (ksa_act) begin
                    ksa_cnt++;
                    if (ksa_cnt == PHASE_CYC && !ksa_hang) begin ksa_finish = 1'b1; ksa_act = 1'b0; end
                end
                if (dec_start) begin
                    dec_act = 1'b1; dec_cnt = 0; dec_bad = bad_keys[key_out[1:0]];
                end else if (dec_act) begin
                    dec_cnt++;
                    mon_wen = 1'b1;
                    mon_sel = 2'd3;
                    if (dec_bad && dec_cnt == bad_pos) begin
                        mon_data = bad_char; bad_sent = 1'b1;
                    end else if (dec_cnt == 5) begin
                        mon_sel = 2'd2; mon_data = 8'h41;
                    end else begin
                        case (dec_cnt % 3)
                            0:       mon_data = 8'h61;
                            1:       mon_data = 8'h7A;
                            default: mon_data = 8'h20;
                        endcase
                    end
                    if (dec_cnt == PHASE_CYC) begin dec_finish = 1'b1; dec_act = 1'b0; end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            step(1);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  bad_keys;
        int          bad_pos;
        logic [7:0]  bad_char;
        bit          ksa_hang;
        bit          restart_mid;
        bit          exp_found;
        bit          exp_failed;
        bit          exp_timeout;
        logic [23:0] exp_key;
        int          exp_inits;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{4'b0000, 1,  8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1};
        vecs[1] = '{4'b0111, 1,  8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000003, 4};
        vecs[2] = '{4'b1111, 3,  8'h7B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000003, 4};
        vecs[3] = '{4'b0001, 10, 8'h60, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000001, 2};
        vecs[4] = '{4'b0011, 1,  8'h1F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000002, 3};
        vecs[5] = '{4'b0000, 1,  8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 1};

        reset = 1'b1; start = 1'b0;
        bad_keys = 4'b0000; bad_pos = 1; bad_char = 8'h41; ksa_hang = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_key", 32'(key_out), 32'd0);
        check("rst_iter", 32'(dec_iterations), 32'd31);
        check("rst_owner", 32'(mem_owner), 32'd0);
        check("rst_status", 32'({found, failed, timeout_err}), 32'd0);
        check("rst_starts", 32'({init_start, ksa_start, dec_start, dec_abort}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            bad_keys = vecs[i].bad_keys;
            bad_pos  = vecs[i].bad_pos;
            bad_char = vecs[i].bad_char;
            ksa_hang = vecs[i].ksa_hang;
            init_pulses = 0;
            pulse_start();
            check($sformatf("v%0d_busy_go", i), 32'(busy), 32'd1);
            check($sformatf("v%0d_init_go", i), 32'(init_start), 32'd1);
            check($sformatf("v%0d_cleared", i), 32'({found, failed, timeout_err}), 32'd0);
            if (vecs[i].restart_mid) begin
                step(40);
                pulse_start();
            end
            wait_idle($sformatf("v%0d_done", i));
            step(3);
            $display("vec %0d: key=%0h found=%0b failed=%0b timeout=%0b inits=%0d",
                     i, key_out, found, failed, timeout_err, init_pulses);
            check($sformatf("v%0d_found", i), 32'(found), 32'(vecs[i].exp_found));
            check($sformatf("v%0d_failed", i), 32'(failed), 32'(vecs[i].exp_failed));
            check($sformatf("v%0d_timeout", i), 32'(timeout_err), 32'(vecs[i].exp_timeout));
            check($sformatf("v%0d_key", i), 32'(key_out), 32'(vecs[i].exp_key));
            check($sformatf("v%0d_inits", i), 32'(init_pulses), 32'(vecs[i].exp_inits));
            check($sformatf("v%0d_owner", i), 32'(mem_owner), 32'd0);
        end

        // Watchdog expiry timing relative to ksa_start.
        bad_keys = 4'b0000; ksa_hang = 1'b1;
        pulse_start();
        n = 0;
        while (!ksa_start && n < 100) begin step(1); n++; end
        check("to_ksa_start", 32'(ksa_start), 32'd1);
        step(15);
        check("to_not_yet", 32'(timeout_err), 32'd0);
        check("to_owner_wait", 32'(mem_owner), 32'd2);
        step(1);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_owner_none", 32'(mem_owner), 32'd0);
        $display("timeout seq: timeout_err=%0b busy=%0b", timeout_err, busy);

        // Reset while waiting on decrypt of key 2.
        ksa_hang = 1'b0; bad_keys = 4'b0011; bad_pos = 1; bad_char = 8'h41;
        pulse_start();
        n = 0;
        while (!(dec_start && key_out == 24'h000002) && n < 500) begin step(1); n++; end
        check("rs_dec_go_k2", 32'(dec_start), 32'd1);
        step(3);
        check("rs_in_dec_wait", 32'(mem_owner), 32'd3);
        reset = 1'b1;
        step(1);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_key", 32'(key_out), 32'd0);
        check("rs_owner", 32'(mem_owner), 32'd0);
        reset = 1'b0;
        start_pulses = 0;
        step(30);
        check("rs_no_starts", 32'(start_pulses), 32'd0);
        check("rs_idle", 32'(busy), 32'd0);
        $display("reset seq: key=%0h owner=%0d starts=%0d", key_out, mem_owner, start_pulses);

        // Bad byte at k=2 of key 0.
        bad_keys = 4'b0001; bad_pos = 2; bad_char = 8'h41;
        abort_pulses = 0;
        pulse_start();
        n = 0;
        while (!bad_sent && n < 200) begin step(1); n++; end
        check("ab_bad_sent", 32'(bad_sent), 32'd1);
        step(1);
`ifdef KEY_SEARCH_EARLY_ABORT_EN
        check("ab_abort", 32'(dec_abort), 32'd1);
        check("ab_owner", 32'(mem_owner), 32'd3);
        step(1);
        check("ab_abort_done", 32'(dec_abort), 32'd0);
        check("ab_no_init_yet", 32'(init_start), 32'd0);
        step(1);
        check("ab_init", 32'(init_start), 32'd1);
        check("ab_key", 32'(key_out), 32'd1);
        wait_idle("ab_done");
        check("ab_pulses", 32'(abort_pulses), 32'd1);
`else
        check("ab_no_abort", 32'(dec_abort), 32'd0);
        check("ab_still_dec", 32'(mem_owner), 32'd3);
        wait_idle("ab_done");
        check("ab_pulses", 32'(abort_pulses), 32'd0);
`endif
        check("ab_found", 32'(found), 32'd1);
        check("ab_found_key", 32'(key_out), 32'd1);
        $display("abort seq: key=%0h found=%0b aborts=%0d", key_out, found, abort_pulses);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
